// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin whole-frame arbiter for two nibble-wide Ethernet TX sources, with an inter-frame gap.
// Define ARB_WATCHDOG_EN to abort frames longer than MAX_BEATS and lock the offending source out until it drops req.
module eth_tx_arbiter #(
   parameter int N         = 4,
   parameter int IFG       = 24,
   parameter int MAX_BEATS = 3044
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req,
   output logic [1:0]   gnt,
   input  logic         axiiv0,
   input  logic [N-1:0] axiid0,
   input  logic         axiiv1,
   input  logic [N-1:0] axiid1,
   output logic         axiov,
   output logic [N-1:0] axiod,
   output logic         busy,
   output logic         err
);
   typedef enum logic [1:0] {IDLE, WAIT, SEND, GAP} state_t;
   state_t       state_q, state_d;
   logic [1:0]   gnt_q, gnt_d;
   logic         last_q, last_d;
   logic [7:0]   gap_q, gap_d;
   logic         axiov_q, axiov_d;
   logic [N-1:0] axiod_q, axiod_d;
   logic         sel, vld, abort;
   logic [N-1:0] dat;
   logic [1:0]   elig;
   assign sel = gnt_q[1];
   assign vld = sel ? axiiv1 : axiiv0;
   assign dat = sel ? axiid1 : axiid0;
`ifdef ARB_WATCHDOG_EN
   localparam int CW = $clog2(MAX_BEATS + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    lock_q, lock_d;
   logic          err_q;
   assign abort = (state_q == SEND) && vld && (cnt_q == CW'(MAX_BEATS));
   assign elig  = req & ~lock_q;
   assign err   = err_q;
   // The first beat is accepted in WAIT, so the count starts at 1 on entry to SEND.
   assign cnt_d  = (state_q == SEND) ? cnt_q + CW'(vld) : CW'(state_q == WAIT && vld);
   assign lock_d = (lock_q & req) | (abort ? gnt_q : 2'b00);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         lock_q <= 2'b00;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         lock_q <= lock_d;
         err_q  <= abort;
      end
   end
`else
   assign abort = (MAX_BEATS < 0);
   assign elig  = req;
   assign err   = 1'b0;
`endif
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      gap_d   = gap_q;
      axiov_d = 1'b0;
      axiod_d = axiod_q;
      case (state_q)
         IDLE: if (|elig) begin
            gnt_d   = (elig == 2'b11) ? (last_q ? 2'b01 : 2'b10) : elig;
            state_d = WAIT;
         end
         WAIT: if (vld) begin
            axiov_d = 1'b1;
            axiod_d = dat;
            state_d = SEND;
         end else if (!req[sel]) begin
            gnt_d   = 2'b00;
            state_d = IDLE;
         end
         SEND: if (vld && !abort) begin
            axiov_d = 1'b1;
            axiod_d = dat;
         end else begin
            gnt_d   = 2'b00;
            last_d  = sel;
            gap_d   = 8'(IFG);
            state_d = GAP;
         end
         GAP: begin
            gap_d = gap_q - 8'd1;
            if (gap_q == 8'd1) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 2'b00;
         last_q  <= 1'b1;
         gap_q   <= 8'd0;
         axiov_q <= 1'b0;
         axiod_q <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         gap_q   <= gap_d;
         axiov_q <= axiov_d;
         axiod_q <= axiod_d;
      end
   end
   assign gnt   = gnt_q;
   assign axiov = axiov_q;
   assign axiod = axiod_q;
   assign busy  = (state_q != IDLE);
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed bench for eth_tx_arbiter; the watchdog scenario changes with ARB_WATCHDOG_EN.
module tb_eth_tx_arbiter;
   localparam int IFG = 24;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] req = 2'b00;
   logic       axiiv0 = 1'b0, axiiv1 = 1'b0;
   logic [3:0] axiid0 = 4'h0, axiid1 = 4'h0;
   logic [1:0] gnt;
   logic       axiov, busy, err;
   logic [3:0] axiod;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   eth_tx_arbiter #(.N(4), .IFG(IFG), .MAX_BEATS(16)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt),
      .axiiv0(axiiv0), .axiid0(axiid0), .axiiv1(axiiv1), .axiid1(axiid1),
      .axiov(axiov), .axiod(axiod), .busy(busy), .err(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic grant(input logic [1:0] exp);
      cyc();
      chk("gnt", 32'(gnt), 32'(exp));
      chk("gnt_busy", 32'(busy), 32'd1);
   endtask

   // Called on the cycle the grant is first seen; the source starts sending immediately.
   task automatic run_frame(input int s, input int n, input logic [3:0] v, input bit noise, input bit drop);
      for (int k = 0; k < n; k++) begin
         if (s == 0) begin
            axiiv0 = 1'b1;
            axiid0 = v;
         end else begin
            axiiv1 = 1'b1;
            axiid1 = v;
         end
         if (noise) begin
            axiiv1 = k[0];
            axiid1 = 4'hF;
         end
         cyc();
         chk("beat_v", 32'(axiov), 32'd1);
         chk("beat_d", 32'(axiod), 32'(v));
      end
      axiiv0 = 1'b0;
      axiiv1 = 1'b0;
      if (drop) req[s] = 1'b0;
      cyc();
      chk("end_gnt", 32'(gnt), 32'd0);
      chk("end_v", 32'(axiov), 32'd0);
      chk("end_hold", 32'(axiod), 32'(v));
      chk("end_busy", 32'(busy), 32'd1);
      chk("end_err", 32'(err), 32'd0);
   endtask

   // Entered on the first gap cycle; leaves on the first IDLE cycle.
   task automatic gap_wait();
      for (int i = 1; i < IFG; i++) begin
         cyc();
         chk("gap_v", 32'(axiov), 32'd0);
         chk("gap_busy", 32'(busy), 32'd1);
         chk("gap_gnt", 32'(gnt), 32'd0);
      end
      cyc();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_gnt", 32'(gnt), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      cyc();
      cyc();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_v", 32'(axiov), 32'd0);
      chk("rst_d", 32'(axiod), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      cyc();
      chk("idle_gnt0", 32'(gnt), 32'd0);

      req = 2'b01;
      grant(2'b01);
      req = 2'b00;
      cyc();
      chk("wd_gnt", 32'(gnt), 32'd0);
      chk("wd_busy", 32'(busy), 32'd0);
      req = 2'b11;
      grant(2'b01);
      req = 2'b00;
      cyc();
      chk("wd2_gnt", 32'(gnt), 32'd0);
      chk("wd2_busy", 32'(busy), 32'd0);

      req = 2'b01;
      grant(2'b01);
      run_frame(0, 10, 4'hA, 1'b0, 1'b1);
      gap_wait();

      req = 2'b01;
      grant(2'b01);
      run_frame(0, 10, 4'h3, 1'b1, 1'b1);
      gap_wait();

      req = 2'b01;
      grant(2'b01);
      for (int k = 0; k < 5; k++) begin
         axiiv0 = 1'b1;
         axiid0 = 4'h7;
         cyc();
         chk("pre_rst_d", 32'(axiod), 32'h7);
      end
      rst_n = 1'b0;
      #1;
      chk("arst_v", 32'(axiov), 32'd0);
      chk("arst_gnt", 32'(gnt), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_d", 32'(axiod), 32'd0);
      axiiv0 = 1'b0;
      req = 2'b00;
      cyc();
      rst_n = 1'b1;
      req = 2'b10;
      grant(2'b10);
      run_frame(1, 3, 4'hB, 1'b0, 1'b1);
      gap_wait();

      req = 2'b11;
      grant(2'b01);
      run_frame(0, 8, 4'h5, 1'b0, 1'b0);
      gap_wait();
      grant(2'b10);
      run_frame(1, 8, 4'hC, 1'b0, 1'b0);
      gap_wait();
      grant(2'b01);
      run_frame(0, 8, 4'h5, 1'b0, 1'b0);
      req = 2'b00;
      gap_wait();

      req = 2'b01;
      grant(2'b01);
      req = 2'b11;
`ifdef ARB_WATCHDOG_EN
      for (int k = 0; k < 20; k++) begin
         axiiv0 = 1'b1;
         axiid0 = 4'h9;
         cyc();
         if (k < 16) begin
            chk("wdg_v", 32'(axiov), 32'd1);
            chk("wdg_d", 32'(axiod), 32'h9);
            chk("wdg_err0", 32'(err), 32'd0);
         end else if (k == 16) begin
            chk("wdg_abort_v", 32'(axiov), 32'd0);
            chk("wdg_err", 32'(err), 32'd1);
            chk("wdg_gnt", 32'(gnt), 32'd0);
         end else begin
            chk("wdg_tail_v", 32'(axiov), 32'd0);
            chk("wdg_tail_err", 32'(err), 32'd0);
         end
      end
      axiiv0 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         chk("wdg_gap_gnt", 32'(gnt), 32'd0);
         chk("wdg_gap_busy", 32'(busy), 32'd1);
      end
      cyc();
      chk("wdg_idle", 32'(busy), 32'd0);
      grant(2'b10);
      run_frame(1, 4, 4'h6, 1'b0, 1'b1);
      gap_wait();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("lock_gnt", 32'(gnt), 32'd0);
         chk("lock_busy", 32'(busy), 32'd0);
      end
      req = 2'b00;
      cyc();
      req = 2'b01;
      grant(2'b01);
      req = 2'b00;
      cyc();
      chk("unlock_wd", 32'(gnt), 32'd0);
`else
      run_frame(0, 20, 4'h9, 1'b0, 1'b1);
      gap_wait();
      grant(2'b10);
      run_frame(1, 4, 4'h6, 1'b0, 1'b1);
      gap_wait();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
